// File: rtl/nios_simple_i2c_pkg.sv
// Shared constants for the PCF8574-style I2C target: FSM state codes, counter width, general-call address.
package nios_simple_i2c_pkg;

  localparam int         I2C_BIT_CNT_W  = 4;
  localparam logic [6:0] I2C_GCALL_ADDR = 7'h00;

  typedef logic [2:0] i2c_state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_WR_DATA  = 3'd3;
  localparam logic [2:0] ST_WR_ACK   = 3'd4;
  localparam logic [2:0] ST_RD_DATA  = 3'd5;
  localparam logic [2:0] ST_RD_ACK   = 3'd6;
  localparam logic [2:0] ST_WAIT     = 3'd7;

  // General call is a write-only match: 8'h01 must never be ACKed.
  function automatic logic addr_match(input logic [7:0] b, input logic [6:0] addr,
                                      input logic gcall_en);
    return (b[7:1] == addr) || (gcall_en && (b == {I2C_GCALL_ADDR, 1'b0}));
  endfunction

endpackage

// File: rtl/nios_simple_i2c_filter.sv
// Two-flop synchronizer followed by a stability filter: the output level only follows
// the synchronized pin after FILTER_LEN consecutive differing samples.
module nios_simple_i2c_filter
  import nios_simple_i2c_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  logic [1:0]               sync;
  logic [I2C_BIT_CNT_W-1:0] cnt;

  // Idle bus is high, so the filter wakes up released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == I2C_BIT_CNT_W'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios_simple_i2c_target.sv
// PCF8574-style I2C target: writes land on port_out, reads return port_in.
// Define I2C_TARGET_GCALL_EN to also ACK the general-call write address 8'h00.
module nios_simple_i2c_target
  import nios_simple_i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = 7'h27,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] port_out,
  output logic       port_wr_stb,
  input  logic [7:0] port_in,
  output logic       busy
);

`ifdef I2C_TARGET_GCALL_EN
  localparam logic GCALL_EN = 1'b1;
`else
  localparam logic GCALL_EN = 1'b0;
`endif

  logic scl, sda, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift, shift_in;
  logic [I2C_BIT_CNT_W-1:0] cnt;
  logic rd;
  i2c_state_t state;

  nios_simple_i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .pin(scl_i), .level(scl)
  );
  nios_simple_i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .pin(sda_i), .level(sda)
  );

  // START/STOP qualify on the previous SCL level, so a simultaneous SCL edge is seen first.
  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl_q & sda_q & ~sda;
  assign stop_det  = scl_q & ~sda_q & sda;
  assign shift_in  = {shift[6:0], sda};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shift       <= '0;
      rd          <= 1'b0;
      sda_oe      <= 1'b0;
      port_out    <= 8'h00;
      port_wr_stb <= 1'b0;
      busy        <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      scl_q       <= scl;
      sda_q       <= sda;
      port_wr_stb <= 1'b0;
      if (start_det) begin
        state  <= ST_ADDR;
        cnt    <= '0;
        sda_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shift <= shift_in;
            cnt   <= cnt + 1'b1;
            if (cnt == 4'd7) begin
              cnt <= '0;
              if (addr_match(shift_in, I2C_ADDR, GCALL_EN)) begin
                state <= ST_ADDR_ACK;
                busy  <= 1'b1;
                rd    <= shift_in[0];
                shift <= port_in;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          // cnt==0: pull SDA for the 9th clock; cnt==1: the 9th clock is over.
          ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
            if (cnt == '0) begin
              sda_oe <= 1'b1;
              cnt    <= 4'd1;
            end else if (state == ST_ADDR_ACK && rd) begin
              sda_oe <= ~shift[7];
              shift  <= {shift[6:0], 1'b0};
              cnt    <= 4'd1;
              state  <= ST_RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= '0;
              state  <= ST_WR_DATA;
            end
          end
          ST_WR_DATA: if (scl_rise) begin
            shift <= shift_in;
            cnt   <= cnt + 1'b1;
            if (cnt == 4'd7) begin
              port_out    <= shift_in;
              port_wr_stb <= 1'b1;
              cnt         <= '0;
              state       <= ST_WR_ACK;
            end
          end
          // cnt counts bits already presented; the fall after the 8th releases SDA.
          ST_RD_DATA: if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_oe <= 1'b0;
              cnt    <= '0;
              state  <= ST_RD_ACK;
            end else begin
              sda_oe <= ~shift[7];
              shift  <= {shift[6:0], 1'b0};
              cnt    <= cnt + 1'b1;
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (!sda) begin
              shift <= port_in;
              cnt   <= '0;
              state <= ST_RD_DATA;
            end else begin
              state <= ST_WAIT;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios_simple_i2c_target.sv
// Self-checking bench: a bit-banged I2C master on a wired-AND bus against a spec-level model.
module tb_nios_simple_i2c_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, port_wr_stb, busy;
  logic [7:0] port_out;
  logic [7:0] port_in = 8'h00;
  wire        sda_bus = sda_m & ~sda_oe;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int oe_cnt = 0;

`ifdef I2C_TARGET_GCALL_EN
  localparam bit GCALL = 1'b1;
`else
  localparam bit GCALL = 1'b0;
`endif
  localparam logic [6:0] TADDR = 7'h27;

  logic [7:0] exp_port = 8'h00;

  nios_simple_i2c_target #(.I2C_ADDR(TADDR), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
    .port_out(port_out), .port_wr_stb(port_wr_stb), .port_in(port_in), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (port_wr_stb) stb_cnt <= stb_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  function automatic bit exp_ack(input logic [7:0] a);
    return (a[7:1] == TADDR) || (GCALL && a == 8'h00);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, output bit rb);
    tick(10); sda_m = b; tick(10); scl_m = 1'b1; tick(10); rb = sda_bus; tick(10); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    tick(10); sda_m = 1'b1; tick(10); scl_m = 1'b1; tick(20); sda_m = 1'b0; tick(20); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(10); sda_m = 1'b0; tick(10); scl_m = 1'b1; tick(20); sda_m = 1'b1; tick(30);
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    bit rb;
    for (int i = 7; i >= 0; i--) send_bit(b[i], rb);
    send_bit(1'b1, rb);
    ack = !rb;
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] d);
    bit rb;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, rb);
      d[i] = rb;
    end
    send_bit(!ack, rb);
  endtask

  task automatic test_reset();
    checks += 4;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    if (port_out !== 8'h00) begin errors++; $display("FAIL reset_port_out: got %h want 00", port_out); end
    if (port_wr_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", port_wr_stb); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    bit ack; int s0; logic [7:0] d;
    for (int n = 0; n < 3; n++) begin
      d = (n == 0) ? 8'hA5 : 8'($urandom);
      s0 = stb_cnt;
      i2c_start();
      write_byte({TADDR, 1'b0}, ack);
      checks += 2;
      if (ack !== 1'b1) begin errors++; $display("FAIL wr_addr_ack: got %b want 1", ack); end
      if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
      write_byte(d, ack);
      exp_port = d;
      checks += 3;
      if (ack !== 1'b1) begin errors++; $display("FAIL wr_data_ack: got %b want 1", ack); end
      if (port_out !== exp_port) begin errors++; $display("FAIL wr_port_out: got %h want %h", port_out, exp_port); end
      if (stb_cnt - s0 != 1) begin errors++; $display("FAIL wr_stb_count: got %0d want 1", stb_cnt - s0); end
      i2c_stop();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
    end
  endtask

  task automatic test_multi_write();
    bit ack; int s0; int nb; logic [7:0] d;
    nb = $urandom_range(2, 5);
    s0 = stb_cnt;
    i2c_start();
    write_byte({TADDR, 1'b0}, ack);
    for (int i = 0; i < nb; i++) begin
      d = 8'($urandom);
      write_byte(d, ack);
      exp_port = d;
      checks += 2;
      if (ack !== 1'b1) begin errors++; $display("FAIL mw_ack: byte %0d got %b want 1", i, ack); end
      if (port_out !== exp_port) begin errors++; $display("FAIL mw_port_out: got %h want %h", port_out, exp_port); end
    end
    i2c_stop();
    checks++;
    if (stb_cnt - s0 != nb) begin errors++; $display("FAIL mw_stb_count: got %0d want %0d", stb_cnt - s0, nb); end
  endtask

  task automatic test_read();
    bit ack; int o0; logic [7:0] d;
    for (int n = 0; n < 3; n++) begin
      port_in = (n == 0) ? 8'h3C : 8'($urandom);
      i2c_start();
      write_byte({TADDR, 1'b1}, ack);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("FAIL rd_addr_ack: got %b want 1", ack); end
      read_byte(1'b1, d);
      checks++;
      if (d !== port_in) begin errors++; $display("FAIL rd_byte1: got %h want %h", d, port_in); end
      read_byte(1'b0, d);
      checks += 2;
      if (d !== port_in) begin errors++; $display("FAIL rd_byte2: got %h want %h", d, port_in); end
      if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_release_after_nack: got %b want 0", sda_oe); end
      o0 = oe_cnt;
      read_byte(1'b0, d);
      checks += 2;
      if (d !== 8'hFF) begin errors++; $display("FAIL rd_wait_ignores: got %h want ff", d); end
      if (oe_cnt != o0) begin errors++; $display("FAIL rd_wait_oe: got %0d drive cycles want 0", oe_cnt - o0); end
      i2c_stop();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_after_stop: got %b want 0", busy); end
    end
  endtask

  task automatic test_wrong_addr();
    bit ack; int s0, o0; logic [7:0] a;
    for (int n = 0; n < 4; n++) begin
      a = 8'h40;
      if (n > 0) begin
        a = 8'($urandom);
        while (a[7:1] == TADDR || a[7:1] == 7'h00) a = 8'($urandom);
      end
      s0 = stb_cnt; o0 = oe_cnt;
      i2c_start();
      write_byte(a, ack);
      checks += 2;
      if (ack !== 1'b0) begin errors++; $display("FAIL wa_ack: addr %h got %b want 0", a, ack); end
      if (busy !== 1'b0) begin errors++; $display("FAIL wa_busy: got %b want 0", busy); end
      write_byte(8'hFF, ack);
      i2c_stop();
      checks += 3;
      if (oe_cnt != o0) begin errors++; $display("FAIL wa_oe: got %0d drive cycles want 0", oe_cnt - o0); end
      if (stb_cnt != s0) begin errors++; $display("FAIL wa_stb: got %0d want 0", stb_cnt - s0); end
      if (port_out !== exp_port) begin errors++; $display("FAIL wa_port_out: got %h want %h", port_out, exp_port); end
    end
  endtask

  task automatic test_repeated_start();
    bit ack; logic [7:0] d, r;
    for (int n = 0; n < 2; n++) begin
      d = (n == 0) ? 8'h11 : 8'($urandom);
      port_in = 8'($urandom);
      i2c_start();
      write_byte({TADDR, 1'b0}, ack);
      write_byte(d, ack);
      exp_port = d;
      checks++;
      if (port_out !== exp_port) begin errors++; $display("FAIL rs_port_out: got %h want %h", port_out, exp_port); end
      i2c_start();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy_held: got %b want 1", busy); end
      write_byte({TADDR, 1'b1}, ack);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("FAIL rs_rd_ack: got %b want 1", ack); end
      read_byte(1'b0, r);
      checks++;
      if (r !== port_in) begin errors++; $display("FAIL rs_rd_data: got %h want %h", r, port_in); end
      i2c_stop();
    end
  endtask

  task automatic test_abort();
    bit ack, rb; int s0;
    s0 = stb_cnt;
    i2c_start();
    write_byte({TADDR, 1'b0}, ack);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), rb);
    i2c_stop();
    checks += 3;
    if (port_out !== exp_port) begin errors++; $display("FAIL ab_port_out: got %h want %h", port_out, exp_port); end
    if (stb_cnt != s0) begin errors++; $display("FAIL ab_stb: got %0d want 0", stb_cnt - s0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy: got %b want 0", busy); end
    // reset while the target drives the first (zero) bit of a read
    port_in = 8'h5A;
    i2c_start();
    write_byte({TADDR, 1'b1}, ack);
    tick(10); scl_m = 1'b1; tick(10);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL ab_rd_driving: got %b want 1", sda_oe); end
    reset = 1'b1;
    tick(1);
    exp_port = 8'h00;
    checks += 3;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL ab_reset_oe: got %b want 0", sda_oe); end
    if (port_out !== exp_port) begin errors++; $display("FAIL ab_reset_port: got %h want %h", port_out, exp_port); end
    if (busy !== 1'b0) begin errors++; $display("FAIL ab_reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick(10); scl_m = 1'b0;
    i2c_stop();
  endtask

  task automatic test_gcall();
    bit ack; int s0;
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h00, ack);
    checks += 2;
    if (ack !== GCALL) begin errors++; $display("FAIL gc_addr_ack: got %b want %b", ack, GCALL); end
    if (busy !== GCALL) begin errors++; $display("FAIL gc_busy: got %b want %b", busy, GCALL); end
    write_byte(8'h77, ack);
    if (GCALL) exp_port = 8'h77;
    checks += 3;
    if (ack !== GCALL) begin errors++; $display("FAIL gc_data_ack: got %b want %b", ack, GCALL); end
    if (port_out !== exp_port) begin errors++; $display("FAIL gc_port_out: got %h want %h", port_out, exp_port); end
    if (stb_cnt - s0 != int'(GCALL)) begin errors++; $display("FAIL gc_stb: got %0d want %0d", stb_cnt - s0, GCALL); end
    i2c_stop();
    i2c_start();
    write_byte(8'h01, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL gc_read_ack: got %b want 0", ack); end
    i2c_stop();
  endtask

  task automatic test_random();
    bit ack; int nb, s0, sel, exp_stb; logic [7:0] a, d, r;
    for (int t = 0; t < 16; t++) begin
      sel = $urandom_range(0, 9);
      a = 8'($urandom);
      if (sel < 6) a[7:1] = TADDR;
      else if (sel < 7) a = 8'h00;
      nb = $urandom_range(1, 3);
      s0 = stb_cnt; exp_stb = 0;
      port_in = 8'($urandom);
      i2c_start();
      write_byte(a, ack);
      checks += 2;
      if (ack !== exp_ack(a)) begin errors++; $display("FAIL rnd_addr_ack: addr %h got %b want %b", a, ack, exp_ack(a)); end
      if (busy !== exp_ack(a)) begin errors++; $display("FAIL rnd_busy: addr %h got %b want %b", a, busy, exp_ack(a)); end
      for (int i = 0; i < nb; i++) begin
        if (a[0]) begin
          read_byte(i != nb - 1, r);
          checks++;
          if (r !== (exp_ack(a) ? port_in : 8'hFF))
            begin errors++; $display("FAIL rnd_rd: addr %h got %h want %h", a, r, exp_ack(a) ? port_in : 8'hFF); end
        end else begin
          d = 8'($urandom);
          write_byte(d, ack);
          if (exp_ack(a)) begin exp_port = d; exp_stb++; end
          checks += 2;
          if (ack !== exp_ack(a)) begin errors++; $display("FAIL rnd_wr_ack: addr %h got %b want %b", a, ack, exp_ack(a)); end
          if (port_out !== exp_port) begin errors++; $display("FAIL rnd_port_out: got %h want %h", port_out, exp_port); end
        end
      end
      i2c_stop();
      checks++;
      if (stb_cnt - s0 != exp_stb) begin errors++; $display("FAIL rnd_stb: got %0d want %0d", stb_cnt - s0, exp_stb); end
    end
  endtask

  initial begin
    tick(4);
    reset = 1'b0;
    tick(4);
    test_reset();
    test_write();
    test_multi_write();
    test_read();
    test_wrong_addr();
    test_repeated_start();
    test_abort();
    test_gcall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
